// File: rtl/cpu_pkg.sv
// Shared processor definitions: datapath width, instruction size, PC-stage
// FSM states and the default reset/trap vectors.
package cpu_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } pc_state_t;

  localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0080;

endpackage

// File: rtl/mux32.sv
// 32-bit 2:1 select stage; sel=1 picks b.
module mux32 (
  input  logic        sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter stage: holds the PC, forms PC+4, branch and jump targets,
// picks the next PC through a three-stage mux chain and qualifies fetch.
//
// state | meaning
// ------+--------------------------------------------------------------
// BOOT  | first cycle after reset; no fetch issued, PC at reset vector
// RUN   | fetching at pc; PC advances when imem_ready and not stall
// TRAP  | misaligned register jump taken; PC at trap vector, no fetch
module pc_next_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        misalign_trap,
  output logic [31:0] epc
);

  pc_state_t   state;
  logic [31:0] branch_target;
  logic [31:0] jump_addr;
  logic [31:0] seq_or_branch;
  logic [31:0] with_jump;
  logic [31:0] next_pc;
  logic        advance;
  logic        misaligned;

  assign pc_plus4      = pc + 32'(INSTR_BYTES);
  // Offset is in words; the shift intentionally discards its top two bits.
  assign branch_target = pc_plus4 + (branch_offset << 2);
  assign jump_addr     = {pc_plus4[31:28], jump_target, 2'b00};

  // Lowest priority first, so the last stage (jump_reg) wins overall.
  mux32 u_mux_branch (
    .sel (branch_taken),
    .a   (pc_plus4),
    .b   (branch_target),
    .y   (seq_or_branch)
  );

  mux32 u_mux_jump (
    .sel (jump),
    .a   (seq_or_branch),
    .b   (jump_addr),
    .y   (with_jump)
  );

  mux32 u_mux_jreg (
    .sel (jump_reg),
    .a   (with_jump),
    .b   (reg_target),
    .y   (next_pc)
  );

  assign advance    = imem_ready & ~stall;
  assign misaligned = jump_reg & (reg_target[1:0] != 2'b00);

  // Sequencing FSM with PC/epc registers and registered fetch/trap outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      pc            <= RESET_VECTOR;
      epc           <= '0;
      fetch_valid   <= 1'b0;
      misalign_trap <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state         <= RUN;
          fetch_valid   <= 1'b1;
          misalign_trap <= 1'b0;
        end
        RUN: begin
          if (advance && misaligned) begin
            state         <= TRAP;
            pc            <= TRAP_VECTOR;
            epc           <= pc;
            fetch_valid   <= 1'b0;
            misalign_trap <= 1'b1;
          end else begin
            if (advance) begin
              pc <= next_pc;
            end
            fetch_valid   <= 1'b1;
            misalign_trap <= 1'b0;
          end
        end
        TRAP: begin
          state         <= RUN;
          fetch_valid   <= 1'b1;
          misalign_trap <= 1'b0;
        end
        default: begin
          state         <= BOOT;
          pc            <= RESET_VECTOR;
          fetch_valid   <= 1'b0;
          misalign_trap <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: directed scenarios plus a randomized run, all
// checked against an instruction-level model of the PC stage.
module tb_pc_next_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        imem_ready;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        jump_reg;
  logic [31:0] reg_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        misalign_trap;
  logic [31:0] epc;

  int checks = 0;
  int errors = 0;

  // Model: what the PC stage should look like after each edge.
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic        m_booting;
  logic        m_in_trap;

  pc_next_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .imem_ready    (imem_ready),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .jump_reg      (jump_reg),
    .reg_target    (reg_target),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .fetch_valid   (fetch_valid),
    .misalign_trap (misalign_trap),
    .epc           (epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_ctrl();
    stall         = 1'b0;
    imem_ready    = 1'b1;
    branch_taken  = 1'b0;
    branch_offset = '0;
    jump          = 1'b0;
    jump_target   = '0;
    jump_reg      = 1'b0;
    reg_target    = '0;
  endtask

  task automatic model_reset();
    m_pc      = 32'h0;
    m_epc     = 32'h0;
    m_booting = 1'b1;
    m_in_trap = 1'b0;
  endtask

  // Instruction-level view of one clock edge using the current inputs.
  task automatic model_edge();
    if (m_booting) begin
      m_booting = 1'b0;
    end else if (m_in_trap) begin
      m_in_trap = 1'b0;
    end else if (imem_ready && !stall) begin
      if (jump_reg && (reg_target % 4 != 0)) begin
        m_epc     = m_pc;
        m_pc      = 32'h80;
        m_in_trap = 1'b1;
      end else if (jump_reg) begin
        m_pc = reg_target;
      end else if (jump) begin
        m_pc = ((m_pc + 32'd4) & 32'hF000_0000) + {6'd0, jump_target} * 32'd4;
      end else if (branch_taken) begin
        m_pc = m_pc + 32'd4 + branch_offset * 32'd4;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // One clock: update the model, take the edge, settle for sampling.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // Move the PC to an aligned address via a register jump.
  task automatic set_pc(input logic [31:0] addr);
    clear_ctrl();
    jump_reg   = 1'b1;
    reg_target = addr;
    tick();
    clear_ctrl();
  endtask

  task automatic test_reset();
    clear_ctrl();
    rst_n = 1'b0;
    model_reset();
    #13;
    checks++;
    if (pc !== 32'h0 || fetch_valid !== 1'b0 || misalign_trap !== 1'b0 || epc !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: pc=%h fv=%b trap=%b epc=%h want pc=0 fv=0 trap=0 epc=0",
               pc, fetch_valid, misalign_trap, epc);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (fetch_valid !== 1'b0 || pc !== 32'h0) begin
      errors++;
      $display("FAIL boot_no_fetch: pc=%h fv=%b want pc=0 fv=0", pc, fetch_valid);
    end
    tick();
    checks++;
    if (fetch_valid !== 1'b1 || pc !== 32'h0) begin
      errors++;
      $display("FAIL boot_to_run: pc=%h fv=%b want pc=0 fv=1", pc, fetch_valid);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (pc !== 32'(4 * i) || pc_plus4 !== 32'(4 * i + 4)) begin
        errors++;
        $display("FAIL seq_fetch[%0d]: pc=%h pc_plus4=%h want %h %h",
                 i, pc, pc_plus4, 32'(4 * i), 32'(4 * i + 4));
      end
    end
  endtask

  task automatic test_branch();
    set_pc(32'h10);
    branch_taken  = 1'b1;
    branch_offset = 32'hFFFF_FFFE;
    tick();
    checks++;
    if (pc !== 32'h0C) begin
      errors++;
      $display("FAIL branch_back: pc=%h want 0000000c", pc);
    end
    set_pc(32'h10);
    branch_taken  = 1'b1;
    branch_offset = 32'h3;
    tick();
    checks++;
    if (pc !== 32'h20) begin
      errors++;
      $display("FAIL branch_fwd: pc=%h want 00000020", pc);
    end
    clear_ctrl();
  endtask

  task automatic test_jump();
    set_pc(32'h4000_0010);
    jump        = 1'b1;
    jump_target = 26'h0000040;
    tick();
    checks++;
    if (pc !== 32'h4000_0100) begin
      errors++;
      $display("FAIL jump_abs: pc=%h want 40000100", pc);
    end
    jump       = 1'b1;
    jump_reg   = 1'b1;
    reg_target = 32'h200;
    tick();
    checks++;
    if (pc !== 32'h200) begin
      errors++;
      $display("FAIL jump_reg_priority: pc=%h want 00000200", pc);
    end
    clear_ctrl();
  endtask

  task automatic test_stall();
    set_pc(32'h100);
    branch_taken  = 1'b1;
    branch_offset = 32'h10;
    stall         = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc !== 32'h100 || fetch_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: pc=%h fv=%b want 00000100 1", i, pc, fetch_valid);
      end
    end
    stall      = 1'b0;
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc !== 32'h100) begin
        errors++;
        $display("FAIL not_ready_hold[%0d]: pc=%h want 00000100", i, pc);
      end
    end
    imem_ready = 1'b1;
    tick();
    checks++;
    if (pc !== 32'h144) begin
      errors++;
      $display("FAIL stall_release: pc=%h want 00000144", pc);
    end
    clear_ctrl();
  endtask

  task automatic test_trap();
    set_pc(32'h30);
    jump_reg   = 1'b1;
    reg_target = 32'h102;
    tick();
    checks++;
    if (pc !== 32'h80 || epc !== 32'h30 || misalign_trap !== 1'b1 || fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL trap_entry: pc=%h epc=%h trap=%b fv=%b want 80 30 1 0",
               pc, epc, misalign_trap, fetch_valid);
    end
    tick();
    checks++;
    if (pc !== 32'h80 || misalign_trap !== 1'b0 || fetch_valid !== 1'b1 || epc !== 32'h30) begin
      errors++;
      $display("FAIL trap_exit: pc=%h epc=%h trap=%b fv=%b want 80 30 0 1",
               pc, epc, misalign_trap, fetch_valid);
    end
    clear_ctrl();
    tick();
    checks++;
    if (pc !== 32'h84 || misalign_trap !== 1'b0) begin
      errors++;
      $display("FAIL trap_resume: pc=%h trap=%b want 84 0", pc, misalign_trap);
    end
  endtask

  task automatic test_wrap_and_reset();
    set_pc(32'hFFFF_FFFC);
    checks++;
    if (pc_plus4 !== 32'h0) begin
      errors++;
      $display("FAIL plus4_wrap: pc_plus4=%h want 00000000", pc_plus4);
    end
    tick();
    checks++;
    if (pc !== 32'h0) begin
      errors++;
      $display("FAIL pc_wrap: pc=%h want 00000000", pc);
    end
    set_pc(32'h30);
    jump_reg   = 1'b1;
    reg_target = 32'h101;
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (pc !== 32'h0 || epc !== 32'h0 || fetch_valid !== 1'b0 || misalign_trap !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_trap: pc=%h epc=%h fv=%b trap=%b want 0 0 0 0",
               pc, epc, fetch_valid, misalign_trap);
    end
    clear_ctrl();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (pc !== 32'h0 || fetch_valid !== 1'b1) begin
      errors++;
      $display("FAIL reboot: pc=%h fv=%b want 0 1", pc, fetch_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] prev_pc;
    logic        expect_pulse;
    for (int n = 0; n < 400; n++) begin
      stall         = ($urandom_range(0, 4) == 0);
      imem_ready    = ($urandom_range(0, 5) != 0);
      branch_taken  = $urandom_range(0, 1) == 1;
      branch_offset = $urandom();
      jump          = ($urandom_range(0, 3) == 0);
      jump_target   = 26'($urandom());
      jump_reg      = ($urandom_range(0, 5) == 0);
      reg_target    = $urandom();
      if ($urandom_range(0, 1) == 1) reg_target[1:0] = 2'b00;
      prev_pc      = m_pc;
      expect_pulse = !m_booting && !m_in_trap && imem_ready && !stall &&
                     jump_reg && (reg_target[1:0] != 2'b00);
      tick();
      checks++;
      if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || epc !== m_epc ||
          misalign_trap !== expect_pulse || fetch_valid !== !m_in_trap) begin
        errors++;
        $display("FAIL random[%0d]: from pc=%h got pc=%h p4=%h epc=%h trap=%b fv=%b want pc=%h epc=%h trap=%b fv=%b",
                 n, prev_pc, pc, pc_plus4, epc, misalign_trap, fetch_valid,
                 m_pc, m_epc, expect_pulse, !m_in_trap);
      end
    end
    clear_ctrl();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_ctrl();
    model_reset();
    test_reset();
    test_branch();
    test_jump();
    test_stall();
    test_trap();
    test_wrap_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
